// File: rtl/ssd_multi_driver.sv
// Seven-segment scan driver: hex or double-dabble decimal conversion, leading-zero blanking, overflow dashes.
// Optional macro SSD_BRIGHTNESS_EN adds a 4-bit brightness input that PWMs the anode within each digit slot.
module ssd_multi_driver #(
    parameter int DIGITS       = 4,
    parameter int VALUE_W      = 16,
    parameter int REFRESH_BITS = 17
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [VALUE_W-1:0]  value,
    input  logic                load,
    input  logic                dec_mode,
    input  logic                blank_lz,
    input  logic [DIGITS-1:0]   dp_mask,
`ifdef SSD_BRIGHTNESS_EN
    input  logic [3:0]          brightness,
`endif
    output logic                busy,
    output logic                overflow,
    output logic [DIGITS-1:0]   anode,
    output logic [6:0]          ssdOut,
    output logic                dp
);

    localparam int BCD_D = (3 * VALUE_W) / 10 + 1;
    localparam int BW    = (BCD_D > DIGITS) ? BCD_D : DIGITS;
    localparam int WIDE  = (VALUE_W > 4 * DIGITS) ? VALUE_W : 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(VALUE_W + 1);

    typedef enum logic [1:0] {IDLE, HEX, SHIFT, COMMIT} state_t;

    state_t                   state_q, state_d;
    logic [VALUE_W-1:0]       val_q, val_d;
    logic                     dec_q, dec_d;
    logic                     blz_q, blz_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [4*BCD_D-1:0]       bcd_q, bcd_d;
    logic [VALUE_W-1:0]       sh_q, sh_d;
    logic [4*DIGITS-1:0]      hex_dig_q, hex_dig_d;
    logic                     hex_ovf_q, hex_ovf_d;
    logic [4*DIGITS-1:0]      disp_dig_q, disp_dig_d;
    logic                     disp_ovf_q, disp_ovf_d;
    logic                     disp_blz_q, disp_blz_d;
    logic [REFRESH_BITS-1:0]  presc_q, presc_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [DIGITS-1:0]        anode_q, anode_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;

    logic [WIDE-1:0]          val_ext;
    logic [4*BW-1:0]          bcd_ext;
    logic [DIGITS-1:0]        blank;

    function automatic logic [4*BCD_D-1:0] dabble_step(input logic [4*BCD_D-1:0] b,
                                                       input logic bit_in);
        logic [4*BCD_D-1:0] adj;
        adj = b;
        for (int i = 0; i < BCD_D; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        return {adj[4*BCD_D-2:0], bit_in};
    endfunction

    // Active-low {a,b,c,d,e,f,g}; b and d use lowercase glyphs.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0: return 7'h01;
            4'h1: return 7'h4F;
            4'h2: return 7'h12;
            4'h3: return 7'h06;
            4'h4: return 7'h4C;
            4'h5: return 7'h24;
            4'h6: return 7'h20;
            4'h7: return 7'h0F;
            4'h8: return 7'h00;
            4'h9: return 7'h04;
            4'hA: return 7'h08;
            4'hB: return 7'h60;
            4'hC: return 7'h31;
            4'hD: return 7'h42;
            4'hE: return 7'h30;
            default: return 7'h38;
        endcase
    endfunction

    assign val_ext  = WIDE'(val_q);
    assign bcd_ext  = (4*BW)'(bcd_q);
    assign busy     = (state_q != IDLE);
    assign overflow = disp_ovf_q;
    assign anode    = anode_q;
    assign ssdOut   = seg_q;
    assign dp       = dp_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load) state_d = dec_mode ? SHIFT : HEX;
            HEX:     state_d = COMMIT;
            SHIFT:   if (cnt_q == CNT_W'(VALUE_W)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        val_d      = val_q;
        dec_d      = dec_q;
        blz_d      = blz_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        sh_d       = sh_q;
        hex_dig_d  = hex_dig_q;
        hex_ovf_d  = hex_ovf_q;
        disp_dig_d = disp_dig_q;
        disp_ovf_d = disp_ovf_q;
        disp_blz_d = disp_blz_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    val_d = value;
                    dec_d = dec_mode;
                    blz_d = blank_lz;
                    cnt_d = '0;
                end
            end
            HEX: begin
                hex_dig_d = val_ext[4*DIGITS-1:0];
                hex_ovf_d = (val_ext >> (4 * DIGITS)) != '0;
            end
            SHIFT: begin
                // Count 0 primes the working registers; counts 1..VALUE_W each shift one bit.
                if (cnt_q == '0) begin
                    bcd_d = '0;
                    sh_d  = val_q;
                end else begin
                    bcd_d = dabble_step(bcd_q, sh_q[VALUE_W-1]);
                    sh_d  = sh_q << 1;
                end
                cnt_d = cnt_q + 1'b1;
            end
            COMMIT: begin
                disp_dig_d = dec_q ? bcd_ext[4*DIGITS-1:0] : hex_dig_q;
                disp_ovf_d = dec_q ? ((bcd_ext >> (4 * DIGITS)) != '0) : hex_ovf_q;
                disp_blz_d = blz_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        logic found;
        found = 1'b0;
        blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (disp_dig_q[4*i +: 4] != 4'h0) found = 1'b1;
            blank[i] = disp_blz_q && !found;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (&presc_q) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    always_comb begin
`ifdef SSD_BRIGHTNESS_EN
        logic [REFRESH_BITS+3:0] pext;
        pext = {presc_q, 4'b0000};
`endif
        anode_d = '1;
`ifdef SSD_BRIGHTNESS_EN
        if (pext[REFRESH_BITS+3 -: 4] < brightness) anode_d[idx_q] = 1'b0;
`else
        anode_d[idx_q] = 1'b0;
`endif
        if (disp_ovf_q)          seg_d = 7'h7E;
        else if (blank[idx_q])   seg_d = 7'h7F;
        else                     seg_d = seg_decode(disp_dig_q[4*idx_q +: 4]);
        dp_d = ~dp_mask[idx_q];
    end

    // Control, display register and scan state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            disp_dig_q <= '0;
            disp_ovf_q <= 1'b0;
            disp_blz_q <= 1'b1;
            presc_q    <= '0;
            idx_q      <= '0;
            anode_q    <= '1;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            disp_dig_q <= disp_dig_d;
            disp_ovf_q <= disp_ovf_d;
            disp_blz_q <= disp_blz_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            anode_q    <= anode_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    // Conversion working registers; only meaningful while busy.
    always_ff @(posedge clk) begin
        val_q     <= val_d;
        dec_q     <= dec_d;
        blz_q     <= blz_d;
        cnt_q     <= cnt_d;
        bcd_q     <= bcd_d;
        sh_q      <= sh_d;
        hex_dig_q <= hex_dig_d;
        hex_ovf_q <= hex_ovf_d;
    end

endmodule

// File: tb/tb_ssd_multi_driver.sv
// Bench for ssd_multi_driver: directed scenarios plus random values checked against an arithmetic display model.
module tb_ssd_multi_driver;
    localparam int D  = 4;
    localparam int VW = 16;
    localparam int RB = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [VW-1:0] value = '0;
    logic load = 1'b0, dec_mode = 1'b0, blank_lz = 1'b0;
    logic [D-1:0] dp_mask = 4'b0100;
    logic busy, overflow, dp;
    logic [D-1:0] anode;
    logic [6:0] ssdOut;

    logic [VW-1:0] value2 = '0;
    logic load2 = 1'b0, dec2 = 1'b0, blz2 = 1'b0;
    logic [2:0] dp_mask2 = 3'b010;
    logic busy2, overflow2, dp2;
    logic [2:0] anode2;
    logic [6:0] ssd2;

    int checks = 0;
    int errors = 0;

    logic [6:0] fr_seg [4];
    bit         fr_seen [4];
    int         fr_bad;
    string      segs [16];

    ssd_multi_driver #(.DIGITS(D), .VALUE_W(VW), .REFRESH_BITS(RB)) dut (
        .clk(clk), .reset_n(reset_n), .value(value), .load(load), .dec_mode(dec_mode),
        .blank_lz(blank_lz), .dp_mask(dp_mask), .busy(busy), .overflow(overflow),
        .anode(anode), .ssdOut(ssdOut), .dp(dp));

    ssd_multi_driver #(.DIGITS(3), .VALUE_W(VW), .REFRESH_BITS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .value(value2), .load(load2), .dec_mode(dec2),
        .blank_lz(blz2), .dp_mask(dp_mask2), .busy(busy2), .overflow(overflow2),
        .anode(anode2), .ssdOut(ssd2), .dp(dp2));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    // Lit segments per hex digit, as letters a..g.
    function automatic logic [6:0] glyph(int d);
        logic [6:0] lit;
        string s;
        lit = '0;
        s = segs[d];
        for (int k = 0; k < s.len(); k++) lit[6 - (int'(s[k]) - 97)] = 1'b1;
        return ~lit;
    endfunction

    function automatic longint ipow(int b, int e);
        longint r = 1;
        for (int k = 0; k < e; k++) r = r * b;
        return r;
    endfunction

    function automatic bit model_ovf(longint v, bit dec);
        return v >= ipow(dec ? 10 : 16, D);
    endfunction

    function automatic logic [6:0] model_seg(longint v, bit dec, bit blz, int i);
        int base, msd;
        longint dig;
        base = dec ? 10 : 16;
        if (model_ovf(v, dec)) return 7'h7E;
        msd = 0;
        for (int j = 0; j < D; j++) if ((v / ipow(base, j)) % base != 0) msd = j;
        if (blz && i > msd) return 7'h7F;
        dig = (v / ipow(base, i)) % base;
        return glyph(int'(dig));
    endfunction

    task automatic convert(input logic [VW-1:0] v, input bit dec, input bit blz, output int n);
        @(negedge clk);
        value = v; dec_mode = dec; blank_lz = blz; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic read_frame();
        int nlow, idx;
        fr_bad = 0;
        for (int i = 0; i < D; i++) begin fr_seen[i] = 1'b0; fr_seg[i] = 'x; end
        @(negedge clk);
        repeat (18) begin
            @(negedge clk);
            nlow = 0; idx = 0;
            for (int i = 0; i < D; i++) if (anode[i] === 1'b0) begin nlow++; idx = i; end
            if (nlow != 1) fr_bad++;
            else begin
                fr_seg[idx] = ssdOut;
                fr_seen[idx] = 1'b1;
                if (dp !== ~dp_mask[idx]) fr_bad++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (anode !== 4'hF) begin errors++; $display("FAIL reset_anode: got %h expected f", anode); end
        checks++; if (ssdOut !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", ssdOut); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
        checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_flags: busy=%b ovf=%b expected 0 0", busy, overflow); end
        reset_n = 1'b1;
        read_frame();
        checks++; if (fr_bad !== 0) begin errors++; $display("FAIL reset_scan: %0d bad samples, expected 0", fr_bad); end
        for (int i = 0; i < D; i++) begin
            logic [6:0] e;
            e = (i == 0) ? 7'h01 : 7'h7F;
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== e) begin errors++; $display("FAIL reset_digit%0d: got %h expected %h", i, fr_seg[i], e); end
        end
    endtask

    task automatic test_hex();
        int n;
        logic [6:0] e [4];
        e = '{7'h38, 7'h30, 7'h30, 7'h60};
        convert(16'hBEEF, 1'b0, 1'b0, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL hex_busy: got %0d cycles expected 2", n); end
        read_frame();
        checks++; if (fr_bad !== 0) begin errors++; $display("FAIL hex_scan: %0d bad samples, expected 0", fr_bad); end
        for (int i = 0; i < D; i++) begin
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== e[i]) begin errors++; $display("FAIL hex_digit%0d: got %h expected %h", i, fr_seg[i], e[i]); end
        end
    endtask

    task automatic test_decimal();
        int n;
        logic [6:0] e [4];
        e = '{7'h4C, 7'h06, 7'h12, 7'h4F};
        convert(16'd1234, 1'b1, 1'b1, n);
        checks++; if (n !== 18) begin errors++; $display("FAIL dec_busy: got %0d cycles expected 18", n); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL dec_ovf: got %b expected 0", overflow); end
        read_frame();
        for (int i = 0; i < D; i++) begin
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== e[i]) begin errors++; $display("FAIL dec1234_digit%0d: got %h expected %h", i, fr_seg[i], e[i]); end
        end
        convert(16'd7, 1'b1, 1'b1, n);
        read_frame();
        for (int i = 0; i < D; i++) begin
            logic [6:0] x;
            x = (i == 0) ? 7'h0F : 7'h7F;
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== x) begin errors++; $display("FAIL dec7_digit%0d: got %h expected %h", i, fr_seg[i], x); end
        end
    endtask

    task automatic test_overflow();
        int n;
        convert(16'd65535, 1'b1, 1'b1, n);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        read_frame();
        checks++; if (fr_bad !== 0) begin errors++; $display("FAIL ovf_dp_scan: %0d bad samples, expected 0", fr_bad); end
        for (int i = 0; i < D; i++) begin
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== 7'h7E) begin errors++; $display("FAIL ovf_digit%0d: got %h expected 7e", i, fr_seg[i]); end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        value = 16'd1234; dec_mode = 1'b1; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_flags: busy=%b ovf=%b expected 0 0", busy, overflow); end
        checks++; if (anode !== 4'hF || ssdOut !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL midrst_outs: an=%h seg=%h dp=%b expected f 7f 1", anode, ssdOut, dp); end
        reset_n = 1'b1;
        read_frame();
        for (int i = 0; i < D; i++) begin
            logic [6:0] x;
            x = (i == 0) ? 7'h01 : 7'h7F;
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== x) begin errors++; $display("FAIL midrst_digit%0d: got %h expected %h", i, fr_seg[i], x); end
        end
    endtask

    task automatic test_load_during_busy();
        int n;
        @(negedge clk);
        value = 16'd1234; dec_mode = 1'b1; blank_lz = 1'b1; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 5) begin value = 16'd5; load = 1'b1; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        checks++; if (n !== 18) begin errors++; $display("FAIL busyload_len: got %0d cycles expected 18", n); end
        read_frame();
        for (int i = 0; i < D; i++) begin
            logic [6:0] x;
            x = model_seg(1234, 1'b1, 1'b1, i);
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== x) begin errors++; $display("FAIL busyload_digit%0d: got %h expected %h", i, fr_seg[i], x); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        value = 16'hA5C3; dec_mode = 1'b0; blank_lz = 1'b0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 2) begin value = 16'h1111; load = 1'b1; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL commit_load_ignored: busy=%b expected 0", busy); end
        read_frame();
        for (int i = 0; i < D; i++) begin
            logic [6:0] x;
            x = model_seg(32'hA5C3, 1'b0, 1'b0, i);
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== x) begin errors++; $display("FAIL b2b_digit%0d: got %h expected %h", i, fr_seg[i], x); end
        end
        convert(16'h00F0, 1'b0, 1'b1, n);
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_busy: got %0d expected 2", n); end
        read_frame();
        for (int i = 0; i < D; i++) begin
            logic [6:0] x;
            x = (i == 0) ? 7'h01 : (i == 1) ? 7'h38 : 7'h7F;
            checks++;
            if (!fr_seen[i] || fr_seg[i] !== x) begin errors++; $display("FAIL f0_digit%0d: got %h expected %h", i, fr_seg[i], x); end
        end
    endtask

    task automatic test_random();
        int n;
        logic [VW-1:0] v;
        bit dec, blz;
        for (int t = 0; t < 16; t++) begin
            v   = ($urandom % 2 == 0) ? VW'($urandom_range(0, 65535)) : VW'($urandom_range(0, 300));
            dec = 1'($urandom % 2);
            blz = 1'($urandom % 2);
            dp_mask = 4'($urandom);
            convert(v, dec, blz, n);
            checks++; if (n !== (dec ? 18 : 2)) begin errors++; $display("FAIL rnd_busy v=%0d dec=%0d: got %0d expected %0d", v, dec, n, dec ? 18 : 2); end
            checks++; if (overflow !== model_ovf(v, dec)) begin errors++; $display("FAIL rnd_ovf v=%0d dec=%0d: got %b expected %b", v, dec, overflow, model_ovf(v, dec)); end
            read_frame();
            checks++; if (fr_bad !== 0) begin errors++; $display("FAIL rnd_scan: %0d bad samples, expected 0", fr_bad); end
            for (int i = 0; i < D; i++) begin
                logic [6:0] x;
                x = model_seg(v, dec, blz, i);
                checks++;
                if (!fr_seen[i] || fr_seg[i] !== x) begin errors++; $display("FAIL rnd_digit%0d v=%0d dec=%0d blz=%0d: got %h expected %h", i, v, dec, blz, fr_seg[i], x); end
            end
        end
    endtask

    task automatic test_scan_wrap();
        int prev, run, nchg, oh_bad, tr_bad, run_bad, dp_bad, nlow, idx;
        prev = -1; run = 0; nchg = 0; oh_bad = 0; tr_bad = 0; run_bad = 0; dp_bad = 0;
        repeat (40) begin
            @(negedge clk);
            nlow = 0; idx = 0;
            for (int i = 0; i < 3; i++) if (anode2[i] === 1'b0) begin nlow++; idx = i; end
            if (nlow != 1) oh_bad++;
            else begin
                if (dp2 !== ((idx == 1) ? 1'b0 : 1'b1)) dp_bad++;
                if (idx == prev) run++;
                else begin
                    if (prev >= 0) begin
                        if (idx != (prev + 1) % 3) tr_bad++;
                        if (nchg > 0 && run != 4) run_bad++;
                        nchg++;
                    end
                    run = 1;
                    prev = idx;
                end
            end
        end
        checks++; if (oh_bad !== 0) begin errors++; $display("FAIL wrap_onehot: %0d bad samples, expected 0", oh_bad); end
        checks++; if (tr_bad !== 0) begin errors++; $display("FAIL wrap_order: %0d bad steps, expected 0", tr_bad); end
        checks++; if (run_bad !== 0) begin errors++; $display("FAIL wrap_period: %0d slots not 4 cycles, expected 0", run_bad); end
        checks++; if (dp_bad !== 0) begin errors++; $display("FAIL wrap_dp: %0d bad samples, expected 0", dp_bad); end
        checks++; if (nchg < 8) begin errors++; $display("FAIL wrap_steps: got %0d steps, expected at least 8", nchg); end
    endtask

    initial begin
        segs = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                 "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
        test_reset();
        test_hex();
        test_decimal();
        test_overflow();
        test_mid_reset();
        test_load_during_busy();
        test_back_to_back();
        test_scan_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
